// File: rtl/pwm_pkg.sv
// Shared register map, control-bit indices and counter direction for the PWM array.
package pwm_pkg;

   localparam int unsigned ADDR_PERIOD = 0;
   localparam int unsigned ADDR_PRESC  = 1;
   localparam int unsigned ADDR_CTRL   = 2;
   localparam int unsigned ADDR_POL    = 3;
   localparam int unsigned ADDR_DUTY0  = 4;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_CENTER = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre up-down counter and period boundary detect.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] presc,
   input  logic             center,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             boundary
);

   logic [CNT_W-1:0] psc_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   dir_e             dir;
   dir_e             dir_nxt;

   // >= rather than == keeps the counters bounded if a limit shrinks under them
   assign tick = en && (psc_cnt >= presc);

   // next count, direction and boundary for the current tick
   always_comb begin
      cnt_nxt  = cnt;
      dir_nxt  = dir;
      boundary = 1'b0;
      if (tick) begin
         if (!center) begin
            if (cnt >= period) begin
               cnt_nxt  = '0;
               boundary = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end else if (period == '0) begin
            cnt_nxt  = '0;
            dir_nxt  = DIR_UP;
            boundary = 1'b1;
         end else if ((dir == DIR_UP) && (cnt < period)) begin
            cnt_nxt = cnt + CNT_W'(1);
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt_nxt == '0) begin
               boundary = 1'b1;
               dir_nxt  = DIR_UP;
            end else begin
               dir_nxt = DIR_DOWN;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psc_cnt <= '0;
         cnt     <= '0;
         dir     <= DIR_UP;
      end else if (!en) begin
         psc_cnt <= '0;
         cnt     <= '0;
         dir     <= DIR_UP;
      end else begin
         psc_cnt <= tick ? '0 : psc_cnt + CNT_W'(1);
         cnt     <= cnt_nxt;
         dir     <= dir_nxt;
      end
   end

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM generator with shadowed registers reloaded at period boundaries.
module pwm_array
   import pwm_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [CNT_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic [NCH-1:0]   pwm_out,
   output logic             period_tick
);

   logic [CNT_W-1:0] sh_period, sh_presc, act_period, act_presc;
   logic             sh_en, sh_center, act_center;
   logic [NCH-1:0]   sh_pol, act_pol;
   logic [CNT_W-1:0] sh_duty  [NCH];
   logic [CNT_W-1:0] act_duty [NCH];
   logic [CNT_W-1:0] cnt;
   logic             tick, boundary;
   logic [NCH-1:0]   cmp_c;

   // Shadow registers take bus writes; active copies follow them while idle, else at period_tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_period  <= '0;
         sh_presc   <= '0;
         sh_en      <= 1'b0;
         sh_center  <= 1'b0;
         sh_pol     <= '0;
         act_period <= '0;
         act_presc  <= '0;
         act_center <= 1'b0;
         act_pol    <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            sh_duty[i]  <= '0;
            act_duty[i] <= '0;
         end
      end else begin
         if (!sh_en || period_tick) begin
            act_period <= sh_period;
            act_presc  <= sh_presc;
            act_center <= sh_center;
            act_pol    <= sh_pol;
            for (int unsigned i = 0; i < NCH; i++) begin
               act_duty[i] <= sh_duty[i];
            end
         end
         if (wr_en) begin
            case (wr_addr)
               AW'(ADDR_PERIOD): sh_period <= wr_data;
               AW'(ADDR_PRESC):  sh_presc  <= wr_data;
               AW'(ADDR_CTRL): begin
                  sh_en     <= wr_data[CTRL_EN];
                  sh_center <= wr_data[CTRL_CENTER];
               end
               AW'(ADDR_POL):    sh_pol    <= NCH'(wr_data);
               default: ;
            endcase
            for (int unsigned i = 0; i < NCH; i++) begin
               if (wr_addr == AW'(ADDR_DUTY0 + i)) begin
                  sh_duty[i] <= wr_data;
               end
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         AW'(ADDR_PERIOD): rd_data = sh_period;
         AW'(ADDR_PRESC):  rd_data = sh_presc;
         AW'(ADDR_CTRL): begin
            rd_data[CTRL_EN]     = sh_en;
            rd_data[CTRL_CENTER] = sh_center;
         end
         AW'(ADDR_POL):    rd_data = CNT_W'(sh_pol);
         default: ;
      endcase
      for (int unsigned i = 0; i < NCH; i++) begin
         if (rd_addr == AW'(ADDR_DUTY0 + i)) begin
            rd_data = sh_duty[i];
         end
      end
   end

   pwm_timebase #(
      .CNT_W (CNT_W)
   ) u_timebase (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (sh_en),
      .period   (act_period),
      .presc    (act_presc),
      .center   (act_center),
      .cnt      (cnt),
      .tick     (tick),
      .boundary (boundary)
   );

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign cmp_c[g] = (cnt < act_duty[g]) ^ act_pol[g];
   end

   // Disabled channels park at their shadow polarity (inactive level)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_out     <= '0;
         period_tick <= 1'b0;
      end else if (!sh_en) begin
         pwm_out     <= sh_pol;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= cmp_c;
         period_tick <= tick & boundary;
      end
   end

endmodule

// File: tb/tb_pwm_array.sv
// Bench for pwm_array: directed scenarios plus randomized configurations against a closed-form model.
module tb_pwm_array;

   localparam int unsigned NCH   = 4;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned AW    = 5;
   localparam int unsigned NOBS  = 256;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [CNT_W-1:0] wr_data;
   logic [AW-1:0]    rd_addr;
   logic [CNT_W-1:0] rd_data;
   logic [NCH-1:0]   pwm_out;
   logic             period_tick;

   pwm_array #(.NCH(NCH), .CNT_W(CNT_W), .AW(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .pwm_out     (pwm_out),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   int             vectors     = 0;
   int             miscompares = 0;
   int unsigned    c_per, c_psc, c_ctr, c_pol;
   int unsigned    c_duty [NCH];
   logic [NCH-1:0] obs_pwm [NOBS];
   logic           obs_pt  [NOBS];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int unsigned a, input int unsigned d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = CNT_W'(d);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int unsigned a, input int unsigned exp);
      rd_addr = AW'(a);
      #1;
      chk(tag, 32'(rd_data), exp);
   endtask

   // Counter value after k ticks from enable, straight from the waveform definition
   function automatic int unsigned cnt_of(input int unsigned k);
      int unsigned m;
      if (c_ctr == 0) return k % (c_per + 1);
      if (c_per == 0) return 0;
      m = k % (2 * c_per);
      return (m <= c_per) ? m : 2 * c_per - m;
   endfunction

   task automatic configure();
      wr(0, c_per);
      wr(1, c_psc);
      wr(2, 32'hFFFC | (c_ctr << 1));
      wr(3, 32'hFFF0 | c_pol);
      for (int i = 0; i < NCH; i++) wr(4 + i, c_duty[i]);
      wr(20, 32'hABCD);
      rd_chk("rd_period", 0, c_per);
      rd_chk("rd_presc", 1, c_psc);
      rd_chk("rd_ctrl", 2, c_ctr << 1);
      rd_chk("rd_pol", 3, c_pol);
      for (int i = 0; i < NCH; i++) rd_chk("rd_duty", 4 + i, c_duty[i]);
      rd_chk("rd_unmapped", 20, 0);
      chk("idle_pwm", 32'(pwm_out), c_pol);
      chk("idle_ptick", 32'(period_tick), 0);
      @(negedge clk);
   endtask

   // Enable, run n cycles checking every cycle, optionally rewrite one duty at cycle wc, then disable
   task automatic run(input int n, input int wc, input int wch, input int unsigned wval);
      int unsigned    act_d [NCH];
      int unsigned    sh_d  [NCH];
      int unsigned    len, k, cv;
      logic [NCH-1:0] e_pwm, nxt;
      logic           e_pt, tk, bnd;
      for (int i = 0; i < NCH; i++) begin
         act_d[i] = c_duty[i];
         sh_d[i]  = c_duty[i];
      end
      len   = (c_ctr != 0) ? ((c_per == 0) ? 1 : 2 * c_per) : c_per + 1;
      e_pwm = NCH'(c_pol);
      e_pt  = 1'b0;
      wr(2, 1 | (c_ctr << 1));
      for (int c = 0; c < n; c++) begin
         wr_en = 1'b0;
         obs_pwm[c] = pwm_out;
         obs_pt[c]  = period_tick;
         chk("pwm", 32'(pwm_out), 32'(e_pwm));
         chk("ptick", 32'(period_tick), 32'(e_pt));
         k   = c / (c_psc + 1);
         tk  = (c % (c_psc + 1)) == c_psc;
         bnd = tk && (((k + 1) % len) == 0);
         cv  = cnt_of(k);
         for (int i = 0; i < NCH; i++) nxt[i] = (cv < act_d[i]) ^ c_pol[i];
         if (e_pt) for (int i = 0; i < NCH; i++) act_d[i] = sh_d[i];
         if (c == wc) begin
            sh_d[wch] = wval;
            wr_en     = 1'b1;
            wr_addr   = AW'(4 + wch);
            wr_data   = CNT_W'(wval);
         end
         e_pwm = nxt;
         e_pt  = bnd;
         @(negedge clk);
      end
      wr_en = 1'b0;
      wr(2, c_ctr << 1);
      @(negedge clk);
      chk("off_pwm", 32'(pwm_out), c_pol);
      chk("off_ptick", 32'(period_tick), 0);
   endtask

   function automatic int count_bit(input int ch, input int lo, input int hi);
      int s = 0;
      for (int c = lo; c <= hi; c++) s += int'(obs_pwm[c][ch]);
      return s;
   endfunction

   function automatic int count_pt(input int lo, input int hi);
      int s = 0;
      for (int c = lo; c <= hi; c++) s += int'(obs_pt[c]);
      return s;
   endfunction

   initial begin
      int n, wc;
      int eq_cnt;
      reset_n = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_ptick", 32'(period_tick), 0);
      for (int a = 0; a < NCH + 4; a++) rd_chk("rst_rd", a, 0);
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         chk("idle_no_ptick", 32'(period_tick), 0);
         @(negedge clk);
      end

      // Edge mode
      c_per = 9; c_psc = 0; c_ctr = 0; c_pol = 0;
      c_duty[0] = 3; c_duty[1] = 0; c_duty[2] = 10; c_duty[3] = 5;
      configure();
      run(40, -1, 0, 0);
      chk("edge_ch0_width", 32'(count_bit(0, 1, 10)), 3);
      chk("edge_ch1_low", 32'(count_bit(1, 0, 39)), 0);
      chk("edge_ch2_high", 32'(count_bit(2, 1, 30)), 30);
      chk("edge_ptick_cnt", 32'(count_pt(0, 39)), 3);
      chk("edge_ptick_at10", 32'(obs_pt[10]), 1);

      // Centre mode
      c_per = 4; c_psc = 1; c_ctr = 1; c_pol = 0;
      c_duty[0] = 2; c_duty[1] = 0; c_duty[2] = 5; c_duty[3] = 3;
      configure();
      run(50, -1, 0, 0);
      chk("ctr_ch0_width", 32'(count_bit(0, 1, 16)), 6);
      chk("ctr_ptick_cnt", 32'(count_pt(0, 49)), 3);
      chk("ctr_ptick_at16", 32'(obs_pt[16]), 1);

      // Shadow duty update mid-period
      c_per = 9; c_psc = 0; c_ctr = 0; c_pol = 0;
      c_duty[0] = 3; c_duty[1] = 1; c_duty[2] = 2; c_duty[3] = 4;
      configure();
      run(40, 14, 0, 7);
      chk("shadow_old_width", 32'(count_bit(0, 11, 20)), 3);
      chk("shadow_new_width", 32'(count_bit(0, 21, 30)), 7);

      // Polarity with zero duty
      c_per = 9; c_psc = 0; c_ctr = 0; c_pol = 5;
      for (int i = 0; i < NCH; i++) c_duty[i] = 0;
      configure();
      run(20, -1, 0, 0);
      eq_cnt = 0;
      for (int c = 0; c < 20; c++) eq_cnt += (obs_pwm[c] == 4'b0101) ? 1 : 0;
      chk("pol_stays", 32'(eq_cnt), 20);

      // Randomized configurations with a random duty rewrite
      for (int r = 0; r < 6; r++) begin
         c_per = $urandom_range(0, 12);
         c_psc = $urandom_range(0, 3);
         c_ctr = $urandom_range(0, 1);
         c_pol = $urandom_range(0, 15);
         for (int i = 0; i < NCH; i++) c_duty[i] = $urandom_range(0, c_per + 2);
         configure();
         n  = 2 * ((c_ctr != 0) ? ((c_per == 0) ? 1 : 2 * c_per) : c_per + 1) * (c_psc + 1) + 6;
         if (n > 200) n = 200;
         wc = $urandom_range(0, n - 1);
         run(n, wc, $urandom_range(0, NCH - 1), $urandom_range(0, c_per + 2));
      end

      // Asynchronous reset while running
      c_per = 9; c_psc = 0; c_ctr = 0; c_pol = 5;
      for (int i = 0; i < NCH; i++) c_duty[i] = 0;
      configure();
      wr(2, 1);
      repeat (3) @(negedge clk);
      chk("pre_rst_pwm", 32'(pwm_out), 5);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_pwm", 32'(pwm_out), 0);
      chk("async_rst_ptick", 32'(period_tick), 0);
      for (int a = 0; a < NCH + 4; a++) rd_chk("async_rst_rd", a, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
